// File: rtl/axis_sa_arb.sv
// Packet-granular round-robin arbiter that shares one axis_sa array among N stream requesters.
// A tag FIFO remembers the owner of each accepted packet and steers output packets back in order.
module axis_sa_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned R     = 4,
  parameter int unsigned C     = 8,
  parameter int unsigned WX    = 4,
  parameter int unsigned WK    = 8,
  parameter int unsigned WY    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        s_valid_i,
  input  logic [N-1:0]        s_last_i,
  output logic [N-1:0]        s_ready_o,
  input  logic [N*R*WX-1:0]   sx_data_i,
  input  logic [N*C*WK-1:0]   sk_data_i,
  output logic                a_valid_o,
  output logic                a_last_o,
  input  logic                a_ready_i,
  output logic [R*WX-1:0]     ax_data_o,
  output logic [C*WK-1:0]     ak_data_o,
  input  logic                y_valid_i,
  input  logic                y_last_i,
  output logic                y_ready_o,
  input  logic [R*WY-1:0]     y_data_i,
  output logic [N-1:0]        m_valid_o,
  output logic [N-1:0]        m_last_o,
  input  logic [N-1:0]        m_ready_i,
  output logic [N*R*WY-1:0]   m_data_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned TW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {StIdle, StLock} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] gnt_q, gnt_d;
  logic [TW-1:0] ptr_q, ptr_d;
  logic          err_q;

  logic [TW-1:0] tag_mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  logic          empty, full, push, pop;
  logic [TW-1:0] head;
  logic          win_vld;
  logic [TW-1:0] win_idx, cand;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = tag_mem_q[rd_q];

  // First requester with valid set, scanning upward from ptr with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = TW'((32'(ptr_q) + k) % N);
      if (!win_vld && s_valid_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    a_valid_o = 1'b0;
    a_last_o  = 1'b0;
    ax_data_o = '0;
    ak_data_o = '0;
    s_ready_o = '0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Full check at grant time guarantees a locked packet can always push its tag.
        if (win_vld && !full) begin
          gnt_d   = win_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        a_valid_o        = s_valid_i[gnt_q];
        a_last_o         = s_last_i[gnt_q];
        ax_data_o        = sx_data_i[gnt_q*R*WX +: R*WX];
        ak_data_o        = sk_data_i[gnt_q*C*WK +: C*WK];
        s_ready_o[gnt_q] = a_ready_i;
        if (a_valid_o && a_ready_i && a_last_o) begin
          push    = 1'b1;
          ptr_d   = (gnt_q == TW'(N - 1)) ? '0 : gnt_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_valid_o = '0;
    m_last_o  = '0;
    for (int i = 0; i < N; i++) begin
      m_valid_o[i] = y_valid_i && !empty && (head == TW'(i));
      m_last_o[i]  = y_last_i && m_valid_o[i];
    end
  end

  assign y_ready_o = !empty && m_ready_i[head];
  assign pop       = y_valid_i && y_ready_o && y_last_i;
  // Broadcast is gated so every output reads zero during reset.
  assign m_data_o  = rst_i ? '0 : {N{y_data_i}};
  assign busy_o    = (state_q == StLock) || !empty;
  assign err_o     = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_q | (y_valid_i & empty);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_q] <= gnt_q;
  end

endmodule

// File: tb/tb_axis_sa_arb.sv
// Bench for axis_sa_arb: bench-driven requesters and an array stub, with a per-cycle reference
// model of ownership, rotation pointer and tag order checked against every DUT output.
module tb_axis_sa_arb;

  localparam int N     = 3;
  localparam int R     = 2;
  localparam int C     = 2;
  localparam int WX    = 4;
  localparam int WK    = 8;
  localparam int WY    = 16;
  localparam int DEPTH = 2;
  localparam int XW    = R * WX;
  localparam int KW    = C * WK;
  localparam int YW    = R * WY;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_valid, s_last, s_ready;
  logic [N*XW-1:0] sx_data;
  logic [N*KW-1:0] sk_data;
  logic            a_valid, a_last, a_ready;
  logic [XW-1:0]   ax_data;
  logic [KW-1:0]   ak_data;
  logic            y_valid, y_last, y_ready;
  logic [YW-1:0]   y_data;
  logic [N-1:0]    m_valid, m_last, m_ready;
  logic [N*YW-1:0] m_data;
  logic            busy, err;

  axis_sa_arb #(
    .N(N), .R(R), .C(C), .WX(WX), .WK(WK), .WY(WY), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
    .sx_data_i(sx_data), .sk_data_i(sk_data),
    .a_valid_o(a_valid), .a_last_o(a_last), .a_ready_i(a_ready),
    .ax_data_o(ax_data), .ak_data_o(ak_data),
    .y_valid_i(y_valid), .y_last_i(y_last), .y_ready_o(y_ready), .y_data_i(y_data),
    .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready), .m_data_o(m_data),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = idle), rotation pointer, queue of owner tags, sticky error.
  int own = -1;
  int mptr = 0;
  int tq[$];
  bit merr = 1'b0;

  always @(negedge clk) begin : compare
    logic [N-1:0]  esr, emv, eml;
    logic          eav, eal, eyr;
    logic [XW-1:0] eax;
    logic [KW-1:0] eak;
    bit            e, hs_last, pop;
    int            h, cnt, pushv;
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);  chk("rst_a_valid", a_valid, 0);
      chk("rst_a_last", a_last, 0);    chk("rst_ax", ax_data, 0);
      chk("rst_ak", ak_data, 0);       chk("rst_y_ready", y_ready, 0);
      chk("rst_m_valid", m_valid, 0);  chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);    chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      own = -1; mptr = 0; tq.delete(); merr = 1'b0;
    end else begin
      e   = (tq.size() == 0);
      h   = e ? 0 : tq[0];
      cnt = tq.size();
      eav = (own >= 0) ? s_valid[own] : 1'b0;
      eal = (own >= 0) ? s_last[own] : 1'b0;
      esr = '0;
      if (own >= 0 && a_ready) esr[own] = 1'b1;
      eax = (own >= 0) ? sx_data[own*XW +: XW] : '0;
      eak = (own >= 0) ? sk_data[own*KW +: KW] : '0;
      emv = '0;
      if (y_valid && !e) emv[h] = 1'b1;
      eml = y_last ? emv : '0;
      eyr = !e && m_ready[h];
      chk("s_ready", s_ready, esr);    chk("a_valid", a_valid, eav);
      chk("a_last", a_last, eal);      chk("ax_data", ax_data, eax);
      chk("ak_data", ak_data, eak);    chk("m_valid", m_valid, emv);
      chk("m_last", m_last, eml);      chk("y_ready", y_ready, eyr);
      chk("m_data", m_data, {N{y_data}});
      chk("busy", busy, (own >= 0) || !e);
      chk("err", err, merr);
      hs_last = (own >= 0) && eav && a_ready && eal;
      pop     = y_valid && eyr && y_last;
      pushv   = own;
      if (y_valid && e) merr = 1'b1;
      if (hs_last) begin
        mptr = (own + 1) % N;
        own  = -1;
      end else if (own < 0 && cnt < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          if (own < 0 && s_valid[(mptr + k) % N]) own = (mptr + k) % N;
        end
      end
      if (pop) void'(tq.pop_front());
      if (hs_last) tq.push_back(pushv);
    end
  end

  // Requester sources, array stub and observation logs.
  int pkt_q[N][$];
  int beat[N];
  int seq[N];
  int mb[N];
  int pending, ybeat, cyc, arr_beats, ar_mode, mr_mode, first_sv, first_av;
  bit force_y;
  int glog[$];
  int olog[$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = (pkt_q[i].size() > 0);
      s_last[i]  = (pkt_q[i].size() > 0) && (beat[i] == pkt_q[i][0] - 1);
      sx_data[i*XW +: XW] = XW'(i * 16 + seq[i] % 16);
      sk_data[i*KW +: KW] = KW'(((i + 1) * 4096) ^ (seq[i] * 37));
    end
    a_ready = (ar_mode == 0) ? 1'b1 : (cyc % 3 != 0);
    m_ready = (mr_mode == 0) ? '1 : (mr_mode == 1) ? '0 : ((cyc % 2 == 1) ? '1 : '0);
    y_valid = force_y || (pending > 0);
    y_last  = (pending > 0) && (ybeat == C - 1);
    y_data  = YW'(32'h1000 + cyc * 3);
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (first_sv < 0 && s_valid[0]) first_sv = cyc;
      if (first_av < 0 && a_valid) first_av = cyc;
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          seq[i]++;
          if (s_last[i]) begin
            void'(pkt_q[i].pop_front());
            beat[i] = 0;
          end else beat[i]++;
        end
        if (m_valid[i] && m_ready[i]) begin
          mb[i]++;
          olog.push_back(i);
        end
      end
      if (a_valid && a_ready) begin
        arr_beats++;
        if (a_last) begin
          pending++;
          for (int i = 0; i < N; i++) if (s_ready[i]) glog.push_back(i);
        end
      end
      if (y_valid && y_ready) begin
        if (y_last) begin
          pending--;
          ybeat = 0;
        end else ybeat++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pkt_q[i].delete();
      beat[i] = 0;
      mb[i]   = 0;
    end
    pending = 0; ybeat = 0; force_y = 1'b0; arr_beats = 0;
    first_sv = -1; first_av = -1;
    glog.delete(); olog.delete();
    drive();
    repeat (n) step();
    chk("lit_rst_a_valid", a_valid, 1'b0);
    chk("lit_rst_busy", busy, 1'b0);
    chk("lit_rst_err", err, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_idle(input string name, input int bound);
    int  n = 0;
    bit  srcs;
    srcs = 1'b1;
    for (int i = 0; i < N; i++) if (pkt_q[i].size() > 0) srcs = 1'b0;
    while (!(srcs && pending == 0 && !busy) && n < bound) begin
      step();
      n++;
      srcs = 1'b1;
      for (int i = 0; i < N; i++) if (pkt_q[i].size() > 0) srcs = 1'b0;
    end
    chk({name, "_drained"}, (n < bound), 1'b1);
  endtask

  task automatic chk_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < got.size()) chk($sformatf("%s[%0d]", name, k), got[k], exp[k]);
    end
  endtask

  initial begin
    ar_mode = 0; mr_mode = 0; cyc = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    do_reset(3);

    // Single 3-beat packet from req0.
    pkt_q[0].push_back(3);
    drive();
    run_idle("A", 60);
    chk("A_grant_latency", first_av - first_sv, 1);
    chk_log("A_grants", glog, '{0});
    chk("A_m0_beats", mb[0], C);
    chk("A_m1_beats", mb[1], 0);

    // Simultaneous requests from req0 and req1.
    do_reset(2);
    pkt_q[0].push_back(2);
    pkt_q[1].push_back(2);
    drive();
    run_idle("B", 80);
    chk_log("B_grants", glog, '{0, 1});
    chk_log("B_outs", olog, '{0, 0, 1, 1});

    // All requesters continuously valid with 1-beat packets.
    do_reset(2);
    for (int i = 0; i < N; i++) begin
      pkt_q[i].push_back(1);
      pkt_q[i].push_back(1);
    end
    drive();
    run_idle("C", 200);
    chk_log("C_grants", glog, '{0, 1, 2, 0, 1, 2});

    // Tag FIFO full with outputs stalled.
    do_reset(2);
    mr_mode = 1;
    for (int i = 0; i < N; i++) pkt_q[i].push_back(1);
    drive();
    repeat (12) step();
    chk("D_granted", glog.size(), 2);
    chk("D_s_ready", s_ready, 0);
    chk("D_a_valid", a_valid, 1'b0);
    chk("D_busy", busy, 1'b1);
    chk("D_req2_held", pkt_q[2].size(), 1);
    mr_mode = 0;
    drive();
    run_idle("D", 100);
    chk_log("D_grants", glog, '{0, 1, 2});
    chk_log("D_outs", olog, '{0, 0, 1, 1, 2, 2});

    // Backpressure on both sides.
    do_reset(2);
    ar_mode = 1; mr_mode = 2;
    pkt_q[0].push_back(4);
    pkt_q[1].push_back(3);
    drive();
    run_idle("E", 200);
    chk("E_array_beats", arr_beats, 7);
    chk("E_m0_beats", mb[0], C);
    chk("E_m1_beats", mb[1], C);
    chk_log("E_grants", glog, '{0, 1});
    ar_mode = 0; mr_mode = 0;

    // Reset mid-packet; pointer must return to 0 (stale pointer would be 2).
    pkt_q[0].push_back(5);
    drive();
    repeat (3) step();
    chk("F_locked", a_valid, 1'b1);
    do_reset(2);
    chk("F_s_ready", s_ready, 0);
    pkt_q[0].push_back(1);
    pkt_q[2].push_back(1);
    drive();
    run_idle("F", 80);
    chk_log("F_grants", glog, '{0, 2});

    // Output beat with no owner sets the sticky error.
    force_y = 1'b1;
    drive();
    repeat (3) step();
    chk("G_y_ready", y_ready, 1'b0);
    chk("G_m_valid", m_valid, 0);
    chk("G_err", err, 1'b1);
    force_y = 1'b0;
    drive();
    repeat (3) step();
    chk("G_err_sticky", err, 1'b1);
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axis_sa_arb.md
# axis_sa_arb

Packet-granular round-robin arbiter that shares one `axis_sa` systolic array among N AXI-stream requesters. It sits between the requesters' x/k input streams and the array's s-port. It locks the array to one requester per packet. A tag FIFO records which requester owns each accepted packet, and the array's m-port output beats are steered back to that requester in order.

## Interface
Parameters:
- `N`, 2: number of requesters (2..8).
- `R`, 4: array rows; must match the array instance.
- `C`, 8: array columns; must match the array instance.
- `WX`, 4: x element width.
- `WK`, 8: k element width.
- `WY`, 16: y element width.
- `DEPTH`, 4: tag FIFO depth, i.e. the maximum number of packets accepted but not yet fully output (power of 2, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  N  per-requester input valid.
- `s_last`  in  N  per-requester input last.
- `s_ready`  out  N  per-requester input ready.
- `sx_data`  in  N×R×WX  per-requester x beat.
- `sk_data`  in  N×C×WK  per-requester k beat.
- `a_valid`  out  1  to array `s_valid`.
- `a_last`  out  1  to array `s_last`.
- `a_ready`  in  1  from array `s_ready`.
- `ax_data`  out  R×WX  to array `sx_data`.
- `ak_data`  out  C×WK  to array `sk_data`.
- `y_valid`  in  1  from array `m_valid`.
- `y_last`  in  1  from array `m_last`.
- `y_ready`  out  1  to array `m_ready`.
- `y_data`  in  R×WY  from array `m_data`.
- `m_valid`  out  N  per-requester output valid.
- `m_last`  out  N  per-requester output last.
- `m_ready`  in  N  per-requester output ready.
- `m_data`  out  N×R×WY  per-requester output beat. `y_data` is broadcast to all requesters; only the owner's `m_valid` is asserted.
- `busy`  out  1  high when the FSM is in LOCK or the tag FIFO is non-empty.
- `err`  out  1  sticky; set when `y_valid` is high while the tag FIFO is empty.

## Operation
Input FSM has two states.
- **IDLE**:
  - `a_valid` and all `s_ready` are 0.
  - The grant winner is the first requester with `s_valid`=1, searching from `ptr` upward with wrap.
  - If a winner exists and `count < DEPTH`: latch `gnt` = winner, go to LOCK.
  - Otherwise stay in IDLE.
- **LOCK**:
  - `a_valid = s_valid[gnt]`, `a_last = s_last[gnt]`, `ax_data = sx_data[gnt]`, `ak_data = sk_data[gnt]`.
  - `s_ready[gnt] = a_ready`; all other `s_ready` are 0.
  - On a handshake (`a_valid && a_ready`) with `a_last`=1: push `gnt` into the tag FIFO, set `ptr = (gnt+1) mod N`, go to IDLE.
  - Deasserting `s_valid[gnt]` mid-packet keeps the lock. No timeout applies.

Output routing:
- `h` is the tag at the FIFO head; `e` is the FIFO empty flag.
- `m_valid[h] = y_valid && !e`; all other `m_valid` are 0.
- `m_last[i] = y_last && m_valid[i]`.
- `y_ready = !e && m_ready[h]`.
- On `y_valid && y_ready && y_last`: pop the FIFO.
- One packet produces C output beats (the array's framing); the arbiter does not count beats and relies on `y_last`.

Boundary conditions:
- **Push and pop in the same cycle**: `count` is unchanged, FIFO contents stay correct, and the new tag is queued behind the existing ones.
- **FIFO full** (`count == DEPTH`): no new grant is issued. A packet already in LOCK always completes its input, because the full check was made at grant time.
- **FIFO empty with `y_valid`=1**: `y_ready` is 0, so no beat is consumed, and `err` is set.
- **Reset**:
  - `rst` may assert at any time.
  - On reset: FSM goes to IDLE, `ptr`=0, FIFO is emptied, `err`=0.
  - All outputs read 0 while `rst` is high.
  - The array instance must be reset by the same event. In-flight packets are discarded.

## Timing
- Grant latency:
  - `s_valid[i]` rising in IDLE at cycle t (i wins) → LOCK at t+1.
  - `a_valid` and `s_ready[i]` follow at t+1.
- Bubble: exactly one idle cycle after each last-beat handshake before the next packet can be driven.
- Ready path: `s_ready[gnt]` is combinational from `a_ready`, so no extra cycle. `y_ready` is combinational from `m_ready[h]`, and `m_*` from `y_*`, both with zero latency.
- The tag push is visible to the output path in the cycle after the last-beat handshake. This is earlier than the array can emit, because the array's output latency is greater than 1.
- Throughput: packets of B beats take B+1 cycles each when `a_ready` is constantly high.

## Test plan
- Req0 sends a 3-beat packet after reset, with all `m_ready`=1 and a real `axis_sa` (R=4, C=8) → `a_valid` rises 1 cycle after `s_valid[0]`. Req0 receives 8 beats with `m_last[0]` on the 8th; `m_valid[1]` stays 0 throughout; `busy` returns to 0.
- Req0 and req1 both send 2-beat packets, asserting `s_valid` in the same cycle after reset → req0 is served first, then req1 after a 1-cycle bubble. Outputs arrive as 8 beats to req0 followed by 8 beats to req1.
- N=3, all requesters continuously valid with 1-beat packets → grant order is 0,1,2,0,1,2.
- DEPTH=2 with all `m_ready`=0, and three 1-beat packets offered → 2 are granted and the third is held in IDLE with `s_ready`=0. Raising `m_ready` lets the first packet's final beat pop the FIFO, and the third packet is granted on the next IDLE cycle.
- Backpressure:
  - `a_ready` toggled during LOCK → `s_ready[gnt]` mirrors it and beats are neither lost nor duplicated.
  - `m_ready[h]` toggled → `y_ready` mirrors it.
- `rst` pulsed mid-packet in LOCK → all outputs are immediately 0, and after release the FSM is in IDLE with `ptr`=0. A stub that raises `y_valid` with the FIFO empty → `err`=1, held until the next reset.
